// File: rtl/binary_sq_3bit_reg_if.sv
// Operand/result bundle for the registered 3-bit squarer.
//   a, b, c   : operand bits, x = 4a + 2b + c
//   in_valid  : operand qualifier
//   p         : registered square of x (0..49)
//   out_valid : p holds the result of an accepted operand
// master drives the operand side, slave (the squarer) drives the result side.
interface binary_sq_3bit_reg_if;
  logic       a;
  logic       b;
  logic       c;
  logic       in_valid;
  logic [5:0] p;
  logic       out_valid;

  modport master (
    output a, b, c, in_valid,
    input  p, out_valid
  );

  modport slave (
    input  a, b, c, in_valid,
    output p, out_valid
  );
endinterface

// File: rtl/binary_sq_3bit_reg.sv
// Registered 3-bit unsigned squarer: p <= (4a+2b+c)^2 one clock after an
// accepted operand, with a valid qualifier carried alongside.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (wins over in_valid)
//   bus : slave side of binary_sq_3bit_reg_if (a, b, c, in_valid in;
//         p, out_valid out, both straight from flops)
module binary_sq_3bit_reg (
  input  logic                 clk,
  input  logic                 rst,
  binary_sq_3bit_reg_if.slave  bus
);

  logic [5:0] sq;
  logic [5:0] p_q;
  logic       out_valid_q;

  // Sum-of-products square; bit 1 is always zero because a square is
  // never congruent to 2 or 3 modulo 4.
  always_comb begin
    sq    = 6'd0;
    sq[0] = bus.c;
    sq[1] = 1'b0;
    sq[2] = bus.b & ~bus.c;
    sq[3] = bus.c & (bus.a ^ bus.b);
    sq[4] = bus.a & (~bus.b | bus.c);
    sq[5] = bus.a & bus.b;
  end

  // p only loads on an accepted operand, so operand bits are don't-care
  // while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= 6'd0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      p_q         <= sq;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_sq_3bit_reg.sv
module tb_binary_sq_3bit_reg;

  logic clk = 1'b0;
  logic rst;

  binary_sq_3bit_reg_if bus ();

  binary_sq_3bit_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] exp_p;
  logic       exp_v;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the reference model, then check both outputs
  // 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [2:0] x, input string tag);
    int xi;
    rst          = r;
    bus.in_valid = v;
    bus.a        = x[2];
    bus.b        = x[1];
    bus.c        = x[0];
    @(posedge clk);
    xi = int'(x);
    if (r) begin
      exp_p = 6'd0;
      exp_v = 1'b0;
    end else if (v) begin
      exp_p = 6'(xi * xi);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    #1;
    check({tag, "_p"}, bus.p, exp_p);
    check({tag, "_valid"}, {5'd0, bus.out_valid}, {5'd0, exp_v});
  endtask

  initial begin
    logic [2:0] rx;
    logic       rr;
    logic       rv;

    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 1'b1;
    bus.b        = 1'b1;
    bus.c        = 1'b1;

    // Reset held with operand 7 presented
    step(1'b1, 1'b1, 3'd7, "reset0");
    step(1'b1, 1'b1, 3'd7, "reset1");
    check("reset_p_const", bus.p, 6'd0);
    step(1'b0, 1'b1, 3'd7, "release");
    check("release_p_49", bus.p, 6'd49);

    // Exhaustive sweep, back to back
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(i), "sweep");
      check("sweep_p1_zero", {5'd0, bus.p[1]}, 6'd0);
    end
    check("sweep_last_49", bus.p, 6'd49);

    // Hold: x=6 then idle with toggling operand bits
    step(1'b0, 1'b1, 3'd6, "hold_load");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'($urandom_range(0, 7)), "hold");
      check("hold_p_36", bus.p, 6'd36);
    end

    // Reset mid-stream on the edge that would capture 7
    step(1'b0, 1'b1, 3'd5, "mid5");
    step(1'b1, 1'b1, 3'd7, "mid_rst");
    check("mid_not_49", {5'd0, bus.p == 6'd49}, 6'd0);

    // Reset priority with x=3
    step(1'b0, 1'b1, 3'd2, "pri_pre");
    step(1'b1, 1'b1, 3'd3, "priority");

    // Slow stimulus: each operand held for 10 cycles
    for (int x = 0; x < 8; x++) begin
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 1'b1, 3'(x), "slow");
      end
    end

    // Randomised traffic against the arithmetic model
    for (int i = 0; i < 300; i++) begin
      rx = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 19) == 0);
      step(rr, rv, rx, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
